// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths and the memory
// opcodes produced by execute.
package mem_stage_pkg;

  localparam int ALU_OP_W = 8;
  localparam int REG_W    = 32;

  typedef logic [ALU_OP_W-1:0] alu_op_bus_t;
  typedef logic [REG_W-1:0]    reg_bus_t;

  localparam reg_bus_t ZERO_WORD = '0;

  localparam alu_op_bus_t ME_NOP_OP = 8'h00;
  localparam alu_op_bus_t ME_LB_OP  = 8'h20;
  localparam alu_op_bus_t ME_LH_OP  = 8'h21;
  localparam alu_op_bus_t ME_LW_OP  = 8'h23;
  localparam alu_op_bus_t ME_LBU_OP = 8'h24;
  localparam alu_op_bus_t ME_LHU_OP = 8'h25;
  localparam alu_op_bus_t ME_SB_OP  = 8'h28;
  localparam alu_op_bus_t ME_SH_OP  = 8'h29;
  localparam alu_op_bus_t ME_SW_OP  = 8'h2b;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: moves loads/stores one byte per cycle over a byte-wide
// RAM port, stalling the pipeline until the access retires.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  alu_op_bus_t           aluop_i,
  input  logic [31:0]           mem_addr_i,
  output logic [4:0]            wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i,
  output logic [1:0]            state_dbg
);

  // Handshake: while stall_req_o is high the op on the inputs has not retired
  // and upstream must hold every input stable; the op retires in the first
  // cycle stall_req_o is low (IDLE for a NOP, DONE for a memory op).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [23:0] partial, partial_n;
  reg_bus_t    load_q, load_n;

  logic        is_load, is_store, is_byte, is_half, sign_ext;
  logic [1:0]  n_last;
  logic [31:0] raw_word, ext_word;
  logic [1:0]  addr_off;
  logic        addr_en;
  logic [RAM_ADDR_W-1:0] addr_sum;
  logic        unused_addr_hi;

  assign is_load  = (aluop_i == ME_LB_OP) || (aluop_i == ME_LH_OP) || (aluop_i == ME_LW_OP) ||
                    (aluop_i == ME_LBU_OP) || (aluop_i == ME_LHU_OP);
  assign is_store = (aluop_i == ME_SB_OP) || (aluop_i == ME_SH_OP) || (aluop_i == ME_SW_OP);
  assign is_byte  = (aluop_i == ME_LB_OP) || (aluop_i == ME_LBU_OP) || (aluop_i == ME_SB_OP);
  assign is_half  = (aluop_i == ME_LH_OP) || (aluop_i == ME_LHU_OP) || (aluop_i == ME_SH_OP);
  assign sign_ext = (aluop_i == ME_LB_OP) || (aluop_i == ME_LH_OP);
  assign n_last   = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd3);

  // Address arithmetic is done at RAM width so it wraps at the top of RAM.
  assign addr_sum       = mem_addr_i[RAM_ADDR_W-1:0] + RAM_ADDR_W'(addr_off);
  assign unused_addr_hi = ^mem_addr_i[31:RAM_ADDR_W];
  assign state_dbg      = state;

  // Bytes captured so far plus the byte arriving this cycle in lane cnt.
  always_comb begin
    raw_word = {8'h00, partial};
    raw_word[{cnt, 3'b000} +: 8] = ram_din_i;
  end

  always_comb begin
    ext_word = raw_word;
    if (is_byte)      ext_word = {{24{sign_ext & raw_word[7]}}, raw_word[7:0]};
    else if (is_half) ext_word = {{16{sign_ext & raw_word[15]}}, raw_word[15:0]};
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    partial_n   = partial;
    load_n      = load_q;
    wd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = ZERO_WORD;
    stall_req_o = 1'b0;
    ram_wr_o    = 1'b0;
    ram_dout_o  = 8'h00;
    addr_off    = 2'd0;
    addr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (is_load || is_store) begin
          // Byte 0 is issued straight from IDLE so there is no dead cycle.
          stall_req_o = 1'b1;
          addr_en     = 1'b1;
          if (is_store) begin
            ram_wr_o   = 1'b1;
            ram_dout_o = wdata_i[7:0];
            cnt_n      = 2'd1;
            state_n    = (n_last == 2'd0) ? DONE : WR;
          end else begin
            cnt_n   = 2'd0;
            state_n = RD;
          end
        end else begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = wdata_i;
        end
      end
      RD: begin
        // cnt is the lane being captured; the next address is issued alongside.
        stall_req_o = 1'b1;
        if (cnt != n_last) begin
          addr_en   = 1'b1;
          addr_off  = cnt + 2'd1;
          partial_n = raw_word[23:0];
          cnt_n     = cnt + 2'd1;
        end else begin
          load_n  = ext_word;
          state_n = DONE;
        end
      end
      WR: begin
        stall_req_o = 1'b1;
        addr_en     = 1'b1;
        addr_off    = cnt;
        ram_wr_o    = 1'b1;
        ram_dout_o  = wdata_i[{cnt, 3'b000} +: 8];
        if (cnt == n_last) state_n = DONE;
        else               cnt_n   = cnt + 2'd1;
      end
      DONE: begin
        if (is_load) begin
          wd_o    = wd_i;
          wreg_o  = wreg_i & (wd_i != 5'd0);
          wdata_o = load_q;
        end
        cnt_n   = 2'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = ZERO_WORD;
      stall_req_o = 1'b0;
      ram_wr_o    = 1'b0;
      ram_dout_o  = 8'h00;
      addr_en     = 1'b0;
    end
  end

  assign ram_addr_o = addr_en ? addr_sum : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      partial <= 24'd0;
      load_q  <= ZERO_WORD;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      partial <= partial_n;
      load_q  <= load_n;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a byte RAM model with one-cycle read latency,
// a vector table of memory ops, and hand sequences for reset and wrap-around.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int RAM_AW = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic [31:0]       wdata_i;
  alu_op_bus_t       aluop_i;
  logic [31:0]       mem_addr_i;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [31:0]       wdata_o;
  logic              stall_req_o;
  logic [RAM_AW-1:0] ram_addr_o;
  logic              ram_wr_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;
  logic [1:0]        state_dbg;

  logic [7:0]  ram [0:(1<<RAM_AW)-1];
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    alu_op_bus_t op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp_wdata;
    logic        exp_wreg;
    int          exp_done;
  } vec_t;

  vec_t vecs[11];

  mem_stage #(.RAM_ADDR_W(RAM_AW)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stall_req_o(stall_req_o), .ram_addr_o(ram_addr_o),
    .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i),
    .state_dbg(state_dbg)
  );

  // Clock and RAM model.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_din_i <= ram[ram_addr_o];
    if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input alu_op_bus_t op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] wd, input logic wreg);
    aluop_i    = op;
    mem_addr_i = addr;
    wdata_i    = wdata;
    wd_i       = wd;
    wreg_i     = wreg;
  endtask

  function automatic int op_bytes(input alu_op_bus_t op);
    if (op == ME_LB_OP || op == ME_LBU_OP || op == ME_SB_OP) return 1;
    if (op == ME_LH_OP || op == ME_LHU_OP || op == ME_SH_OP) return 2;
    if (op == ME_LW_OP || op == ME_SW_OP) return 4;
    return 0;
  endfunction

  // Called just after a rising edge; returns just after the edge that ends
  // the op's retire cycle, so a following call has no gap.
  task automatic run_op(input vec_t v);
    int          n;
    logic        is_st;
    logic        done;
    logic [31:0] a;
    logic [31:0] exp_w;
    n     = op_bytes(v.op);
    is_st = (v.op == ME_SB_OP || v.op == ME_SH_OP || v.op == ME_SW_OP);
    done  = 1'b0;
    drive(v.op, v.addr, v.wdata, v.wd, v.wreg);
    exp_q.push_back(v.exp_wdata);
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (stall_req_o) begin
        check("bubble", {26'd0, wreg_o, wd_o}, 32'd0);
        check("bubble_data", wdata_o, 32'd0);
        if (c < n) begin
          a = v.addr + c;
          check("ram_addr", {15'd0, ram_addr_o}, {15'd0, a[RAM_AW-1:0]});
          check("ram_wr", {31'd0, ram_wr_o}, {31'd0, is_st});
          if (is_st) check("ram_dout", {24'd0, ram_dout_o}, {24'd0, v.wdata[8*c +: 8]});
        end
      end else begin
        done  = 1'b1;
        exp_w = exp_q.pop_front();
        check("retire_cycle", c, v.exp_done);
        check("retire_wreg", {31'd0, wreg_o}, {31'd0, v.exp_wreg});
        check("retire_ram_wr", {31'd0, ram_wr_o}, 32'd0);
        if (!is_st) begin
          check("retire_wdata", wdata_o, exp_w);
          check("retire_wd", {27'd0, wd_o}, {27'd0, v.wd});
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("retire_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_stall"}, {31'd0, stall_req_o}, 32'd0);
    check({name, "_wdata"}, wdata_o, 32'd0);
    check({name, "_port"}, {ram_wr_o, ram_addr_o, ram_dout_o, wd_o, wreg_o}, 32'd0);
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = 8'h00;
    ram[17'h100] = 8'h78; ram[17'h101] = 8'h56; ram[17'h102] = 8'h34; ram[17'h103] = 8'h12;
    ram[17'h104] = 8'hAA;
    ram[17'h040] = 8'h80;
    ram[17'h204] = 8'h5A;
    ram[17'h300] = 8'h34; ram[17'h301] = 8'h92;
    ram_din_i = 8'h00;

    //            op         addr          wdata          wd     wreg  exp_wdata      exp_wreg done
    vecs[0]  = '{ME_LW_OP,  32'h100,      32'h0,         5'd3,  1'b1, 32'h12345678, 1'b1, 5};
    vecs[1]  = '{ME_LB_OP,  32'h40,       32'h0,         5'd4,  1'b1, 32'hFFFFFF80, 1'b1, 2};
    vecs[2]  = '{ME_LBU_OP, 32'h40,       32'h0,         5'd4,  1'b1, 32'h00000080, 1'b1, 2};
    vecs[3]  = '{ME_SH_OP,  32'h202,      32'hABCD1234,  5'd9,  1'b1, 32'h0,        1'b0, 2};
    vecs[4]  = '{ME_LH_OP,  32'h300,      32'h0,         5'd6,  1'b1, 32'hFFFF9234, 1'b1, 3};
    vecs[5]  = '{ME_LHU_OP, 32'h300,      32'h0,         5'd6,  1'b1, 32'h00009234, 1'b1, 3};
    vecs[6]  = '{ME_LW_OP,  32'h101,      32'h0,         5'd8,  1'b1, 32'hAA123456, 1'b1, 5};
    vecs[7]  = '{ME_LW_OP,  32'h100,      32'h0,         5'd0,  1'b1, 32'h12345678, 1'b0, 5};
    vecs[8]  = '{ME_SB_OP,  32'h210,      32'h000000C3,  5'd2,  1'b0, 32'h0,        1'b0, 1};
    vecs[9]  = '{ME_NOP_OP, 32'h0,        32'hDEADBEEF,  5'd5,  1'b1, 32'hDEADBEEF, 1'b1, 0};
    vecs[10] = '{ME_LB_OP,  32'h210,      32'h0,         5'd1,  1'b1, 32'hFFFFFFC3, 1'b1, 2};

    // Reset with a live op on the inputs: every output must stay 0.
    rst = 1'b1;
    drive(ME_LW_OP, 32'h100, 32'hFFFFFFFF, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_op(vecs[i]);
    check("sh_byte0", {24'd0, ram[17'h202]}, 32'h34);
    check("sh_byte1", {24'd0, ram[17'h203]}, 32'h12);
    check("sh_neighbour", {24'd0, ram[17'h204]}, 32'h5A);

    // Back-to-back store and load across the top of RAM.
    v = '{ME_SW_OP, 32'h1FFFE, 32'hCAFEF00D, 5'd0, 1'b0, 32'h0, 1'b0, 4};
    run_op(v);
    v = '{ME_LW_OP, 32'h1FFFE, 32'h0, 5'd12, 1'b1, 32'hCAFEF00D, 1'b1, 5};
    run_op(v);
    check("wrap_1fffe", {24'd0, ram[17'h1FFFE]}, 32'h0D);
    check("wrap_1ffff", {24'd0, ram[17'h1FFFF]}, 32'hF0);
    check("wrap_00000", {24'd0, ram[17'h00000]}, 32'hFE);
    check("wrap_00001", {24'd0, ram[17'h00001]}, 32'hCA);

    // Reset during cycle 2 of a load, then a clean load afterwards.
    drive(ME_LW_OP, 32'h100, 32'h0, 5'd7, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    drive(ME_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check_all_zero("midrst_next");
    check("midrst_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = '{ME_LB_OP, 32'h40, 32'h0, 5'd4, 1'b1, 32'hFFFFFF80, 1'b1, 2};
    run_op(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
